// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: word width, canonical NOP, fetch FSM encoding and the IF/ID entry type.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FETCH_REQ  = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetchEntry_t;

    function automatic word_t nextPc(input word_t pc, input word_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle; master = fetch side, slave = memory side.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instr/pc holding buffer for a response that lands while IF/ID is stalled.
// Latency: loaded entry visible the cycle after load; clear beats load beats drain.
// Backpressure: full is fed back to the fetch FSM to stop issuing requests.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  fetchEntry_t loadEntry,
    output logic        full,
    output fetchEntry_t entry
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= loadEntry;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: REQ/WAIT/DROP FSM (one outstanding request) feeding the IF/ID register.
// Latency: gnt in N, rvalid in N+1 -> valid_o in N+2. Branch redirect wins over stall.
// Backpressure: stall holds IF/ID, a stalled response parks in the skid buffer and blocks new requests.
// Build option FETCH_NOP_ON_FLUSH_EN: invalidated IF/ID also loads NOP into instr_o.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_f,
    input  logic [31:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_o,
    output logic                 valid_o,
    output logic                 flush_o
);

    logic [1:0]  state;
    word_t       pc;
    word_t       fetchPc;
    word_t       bubbleInstr;
    logic        skidFull;
    fetchEntry_t skidEntry;
    logic        granted;
    logic        newInstr;

    assign imem.imem_req  = !rst && (state == FETCH_REQ) && !skidFull;
    assign imem.imem_addr = pc;

    assign granted  = imem.imem_req && imem.imem_gnt;
    // Only a response to a still-wanted request may reach IF/ID or the skid buffer.
    assign newInstr = (state == FETCH_WAIT) && imem.imem_rvalid && !branch_f;

`ifdef FETCH_NOP_ON_FLUSH_EN
    assign bubbleInstr = NOP_INSTR;
`else
    assign bubbleInstr = instr_o;
`endif

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (stall && newInstr),
        .drain     (!stall && !branch_f && skidFull),
        .clear     (branch_f),
        .loadEntry ('{instr: imem.imem_rdata, pc: fetchPc}),
        .full      (skidFull),
        .entry     (skidEntry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH_REQ;
            pc      <= RESET_PC;
            fetchPc <= '0;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (granted) begin
                        state <= branch_f ? FETCH_DROP : FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state <= FETCH_REQ;
                    end else if (branch_f) begin
                        state <= FETCH_DROP;
                    end
                end
                FETCH_DROP: begin
                    if (imem.imem_rvalid) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase

            if (granted) begin
                fetchPc <= pc;
            end

            if (branch_f) begin
                pc <= branch_target;
            end else if (granted) begin
                pc <= nextPc(pc, 32'(PC_STEP));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_o <= NOP_INSTR;
            pc_o    <= '0;
            valid_o <= 1'b0;
            flush_o <= 1'b0;
        end else begin
            flush_o <= branch_f;
            if (branch_f) begin
                valid_o <= 1'b0;
                instr_o <= bubbleInstr;
            end else if (!stall) begin
                if (skidFull) begin
                    instr_o <= skidEntry.instr;
                    pc_o    <= skidEntry.pc;
                    valid_o <= 1'b1;
                end else if (newInstr) begin
                    instr_o <= imem.imem_rdata;
                    pc_o    <= fetchPc;
                    valid_o <= 1'b1;
                end else begin
                    valid_o <= 1'b0;
                    instr_o <= bubbleInstr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a transaction-level model (pending request, skid queue).
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_f;
    logic [31:0] branch_target;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        flush_o;

    fetch_stage_if imemIf ();

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_f      (branch_f),
        .branch_target (branch_target),
        .imem          (imemIf),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .flush_o       (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;

    // Reference model state: next fetch address, one in-flight request, IF/ID view, skid queue.
    logic [31:0] mPc, mFetchPc, mInstr, mPcO, lastRd, savedRd;
    bit          mPend, mStale, mValid, mFlush;
    logic [63:0] skidQ[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bubbleOf(input logic [31:0] held);
`ifdef FETCH_NOP_ON_FLUSH_EN
        return NOP_INSTR;
`else
        return held;
`endif
    endfunction

    function automatic void modelReset();
        mPc = 32'h0; mFetchPc = 32'h0; mInstr = NOP_INSTR; mPcO = 32'h0;
        mPend = 1'b0; mStale = 1'b0; mValid = 1'b0; mFlush = 1'b0;
        skidQ.delete();
    endfunction

    function automatic void modelStep(input bit st, input bit br, input logic [31:0] tgt,
                                      input bit g, input bit rv, input logic [31:0] rd);
        bit req, granted, resp, fresh;
        req     = !mPend && (skidQ.size() == 0);
        granted = req && g;
        resp    = mPend && rv;
        fresh   = resp && !mStale && !br;
        mFlush  = br;
        if (br) begin
            mValid = 1'b0;
            mInstr = bubbleOf(mInstr);
            skidQ.delete();
        end else if (st) begin
            if (fresh) skidQ.push_back({rd, mFetchPc});
        end else if (skidQ.size() > 0) begin
            {mInstr, mPcO} = skidQ.pop_front();
            mValid = 1'b1;
        end else if (fresh) begin
            mInstr = rd;
            mPcO   = mFetchPc;
            mValid = 1'b1;
        end else begin
            mValid = 1'b0;
            mInstr = bubbleOf(mInstr);
        end
        if (granted) begin
            mPend = 1'b1; mStale = br; mFetchPc = mPc;
        end else if (resp) begin
            mPend = 1'b0;
        end else if (mPend && br) begin
            mStale = 1'b1;
        end
        if (br) mPc = tgt;
        else if (granted) mPc = mPc + 32'd4;
    endfunction

    // One clock: check registered outputs, drive inputs, check the request, advance model.
    task automatic cyc(input bit st, input bit br, input logic [31:0] tgt, input bit g, input bit rv);
        logic [31:0] rd;
        bit expReq;
        rd = $urandom;
        @(negedge clk);
        chk("valid_o", {31'b0, valid_o}, {31'b0, mValid});
        chk("pc_o", pc_o, mPcO);
        chk("instr_o", instr_o, mInstr);
        chk("flush_o", {31'b0, flush_o}, {31'b0, mFlush});
        rst = 1'b0;
        stall = st; branch_f = br; branch_target = tgt;
        imemIf.imem_gnt = g; imemIf.imem_rvalid = rv; imemIf.imem_rdata = rd;
        #1;
        expReq = !mPend && (skidQ.size() == 0);
        chk("imem_req", {31'b0, imemIf.imem_req}, {31'b0, expReq});
        if (expReq) chk("imem_addr", imemIf.imem_addr, mPc);
        @(posedge clk);
        modelStep(st, br, tgt, g, rv, rd);
        lastRd = rd;
    endtask

    initial begin
        bit st, br, g, rv;
        logic [31:0] tgt;
        rst = 1'b1; stall = 1'b0; branch_f = 1'b0; branch_target = 32'h0;
        imemIf.imem_gnt = 1'b0; imemIf.imem_rvalid = 1'b0; imemIf.imem_rdata = 32'h0;
        modelReset();
        #3;
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_instr", instr_o, NOP_INSTR);
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        chk("rst_req", {31'b0, imemIf.imem_req}, 32'h0);
        @(posedge clk); @(posedge clk);

        // Back-to-back fetch from reset
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        #2 chk("first_valid", {31'b0, valid_o}, 32'h1);
        chk("first_pc", pc_o, 32'h0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        #2 chk("second_pc", pc_o, 32'h4);

        // Stall three cycles while the 0x8 response arrives
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        #2 chk("stall_hold_pc", pc_o, 32'h4);
        chk("stall_no_req", {31'b0, imemIf.imem_req}, 32'h0);
        cyc(0, 0, 0, 1, 0);
        #2 chk("skid_to_ifid_pc", pc_o, 32'h8);
        chk("skid_to_ifid_valid", {31'b0, valid_o}, 32'h1);

        // Redirect while waiting: stale response dropped
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 32'h100, 0, 0);
        #2 chk("flush_pulse", {31'b0, flush_o}, 32'h1);
        cyc(0, 0, 0, 0, 1);
        #2 chk("flush_end", {31'b0, flush_o}, 32'h0);
        chk("drop_valid", {31'b0, valid_o}, 32'h0);
        chk("redirect_addr", imemIf.imem_addr, 32'h100);

        // Branch + stall + rvalid together
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 32'h200, 0, 1);
        #2 chk("bsr_valid", {31'b0, valid_o}, 32'h0);
        chk("bsr_req", {31'b0, imemIf.imem_req}, 32'h1);
        chk("bsr_addr", imemIf.imem_addr, 32'h200);

        // PC wrap and invalidation policy
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        savedRd = lastRd;
        #2 chk("wrap_addr", imemIf.imem_addr, 32'h0);
        chk("top_pc", pc_o, 32'hFFFF_FFFC);
        chk("top_instr", instr_o, savedRd);
        cyc(0, 1, 32'h40, 0, 0);
        #2 chk("inval_valid", {31'b0, valid_o}, 32'h0);
        chk("inval_pc_hold", pc_o, 32'hFFFF_FFFC);
        chk("inval_instr", instr_o, bubbleOf(savedRd));

        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            g   = ($urandom_range(0, 3) != 0);
            rv  = mPend ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            cyc(st, br, tgt, g, rv);
        end

        // Asynchronous reset while a request is outstanding
        for (int i = 0; i < 20; i++) begin
            if (mPend) break;
            cyc(0, 0, 0, 1, 0);
        end
        if (!mPend) begin
            nVec++; nMis++;
            $error("FAIL reach_wait: got no outstanding request expected one within 20 cycles");
        end
        @(negedge clk);
        imemIf.imem_gnt = 1'b0; imemIf.imem_rvalid = 1'b0;
        stall = 1'b0; branch_f = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid_o}, 32'h0);
        chk("arst_pc_o", pc_o, 32'h0);
        chk("arst_instr", instr_o, NOP_INSTR);
        chk("arst_flush", {31'b0, flush_o}, 32'h0);
        chk("arst_req", {31'b0, imemIf.imem_req}, 32'h0);
        @(posedge clk);
        modelReset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        #2 chk("post_arst_pc", pc_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
